// File: rtl/div_radix2_iter_pkg.sv
// rtl/div_radix2_iter_pkg.sv - shared state codes and constants for the radix-2 divider
package div_radix2_iter_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

endpackage

// File: rtl/div_radix2_iter_step.sv
// rtl/div_radix2_iter_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] partial_rem,
    input  logic              dividend_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] next_rem,
    output logic              quot_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // The extra top bit of trial is the borrow; a borrow means "restore".
    always_comb begin
        shifted  = {partial_rem, dividend_bit};
        trial    = shifted - {1'b0, divisor};
        quot_bit = ~trial[DATA_W];
        next_rem = quot_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/div_radix2_iter.sv
// rtl/div_radix2_iter.sv - multi-cycle radix-2 restoring divider (DIV/DIVU); optional DIV_ZERO_FAST_EN
module div_radix2_iter
    import div_radix2_iter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] dsr_q;
    logic [DATA_W-1:0] rem_q;
    logic              signed_q;
    logic              sign1_q;
    logic              sign2_q;

    logic              load;
    logic              step;
    logic              finish;
    logic              clear;
`ifdef DIV_ZERO_FAST_EN
    logic              zero_tick;
    logic              zero_fin;
`endif

    logic [DATA_W-1:0] op1_mag;
    logic [DATA_W-1:0] op2_mag;
    logic [DATA_W-1:0] step_rem;
    logic              step_bit;
    logic [DATA_W-1:0] quo_fix;
    logic [DATA_W-1:0] rem_fix;

    div_step #(.DATA_W(DATA_W)) u_step (
        .partial_rem  (rem_q),
        .dividend_bit (dvd_q[DATA_W-1]),
        .divisor      (dsr_q),
        .next_rem     (step_rem),
        .quot_bit     (step_bit)
    );

    // |0x80..0| wraps back to 0x80..0, which is the correct unsigned magnitude.
    always_comb begin
        op1_mag = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        op2_mag = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        quo_fix = (signed_q && (sign1_q ^ sign2_q)) ? -dvd_q : dvd_q;
        rem_fix = (signed_q && sign1_q) ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DIV_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        clear   = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zero_tick = 1'b0;
        zero_fin  = 1'b0;
`endif
        case (state_q)
            DIV_FREE: begin
                if (start_i == DIV_START && !annul_i) begin
                    load = 1'b1;
`ifdef DIV_ZERO_FAST_EN
                    state_d = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
`else
                    state_d = DIV_ON;
`endif
                end
            end
`ifdef DIV_ZERO_FAST_EN
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == CNT_W'(1)) begin
                    zero_fin = 1'b1;
                    state_d  = DIV_END;
                end else begin
                    zero_tick = 1'b1;
                end
            end
`endif
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                end else if (cnt_q == LAST_CNT) begin
                    finish  = 1'b1;
                    state_d = DIV_END;
                end else begin
                    step = 1'b1;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    clear   = 1'b1;
                    state_d = DIV_FREE;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            signed_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            if (load) begin
                signed_q <= signed_div_i;
                sign1_q  <= opdata1_i[DATA_W-1];
                sign2_q  <= opdata2_i[DATA_W-1];
                dvd_q    <= op1_mag;
                dsr_q    <= op2_mag;
                rem_q    <= '0;
                cnt_q    <= '0;
            end
            // dvd_q doubles as the quotient: dividend bits shift out the top as quotient bits shift in.
            if (step) begin
                rem_q <= step_rem;
                dvd_q <= {dvd_q[DATA_W-2:0], step_bit};
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (finish) begin
                result_o <= {rem_fix, quo_fix};
                ready_o  <= DIV_RESULT_READY;
            end
`ifdef DIV_ZERO_FAST_EN
            if (zero_tick) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (zero_fin) begin
                result_o <= '0;
                ready_o  <= DIV_RESULT_READY;
            end
`endif
            if (clear) begin
                result_o <= '0;
                ready_o  <= DIV_RESULT_NOT_READY;
            end
        end
    end

endmodule

// File: tb/tb_div_radix2_iter.sv
// tb/tb_div_radix2_iter.sv - self-checking bench for div_radix2_iter
module tb_div_radix2_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        signed_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int checks = 0;
    int passes = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    div_radix2_iter dut (
        .clk          (clk),
        .resetn       (resetn),
        .signed_div_i (signed_div),
        .opdata1_i    (opa),
        .opdata2_i    (opb),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic run_div(input string name, input logic sgn, input logic [31:0] x,
                           input logic [31:0] y, input logic [63:0] exp, input int lat,
                           input int hold);
        int edges;
        logic [63:0] want;
        @(negedge clk);
        signed_div = sgn; opa = x; opb = y; start = 1'b1; annul = 1'b0;
        sb_q.push_back(exp);
        edges = 0;
        while (edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (ready) break;
            if (edges == 1) begin
                opa = $urandom;
                opb = $urandom;
                signed_div = ~sgn;
            end
        end
        want = sb_q.pop_front();
        if (!ready) begin
            check({name, "_timeout"}, 64'(ready), 64'd1);
        end else begin
            check({name, "_latency"}, 64'(edges - 1), 64'(lat));
            check({name, "_result"}, result, want);
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({name, "_hold_ready"}, 64'(ready), 64'd1);
                check({name, "_hold_result"}, result, want);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_drop_ready"}, 64'(ready), 64'd0);
        check({name, "_drop_result"}, result, 64'd0);
    endtask

    task automatic watch_no_ready(input string name, input int cycles);
        int rises;
        rises = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (ready) rises++;
        end
        check(name, 64'(rises), 64'd0);
    endtask

    initial begin
        logic [31:0] x, y, q, r;
        logic        s;
        int          zlat;

        resetn = 1'b0; signed_div = 1'b0; opa = '0; opb = '0; start = 1'b0; annul = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        zlat = 2;
        vecs.push_back('{"divu_5_0",   1'b0, 32'd5,        32'd0, 32'h0, 32'h0, zlat});
        vecs.push_back('{"div_m8_0",   1'b1, 32'hFFFFFFF8, 32'd0, 32'h0, 32'h0, zlat});
`else
        zlat = 33;
        vecs.push_back('{"divu_5_0",   1'b0, 32'd5,        32'd0, 32'hFFFFFFFF, 32'd5,        zlat});
        vecs.push_back('{"div_m8_0",   1'b1, 32'hFFFFFFF8, 32'd0, 32'h00000001, 32'hFFFFFFF8, zlat});
`endif
        vecs.push_back('{"divu_100_7", 1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        33});
        vecs.push_back('{"div_m7_2",   1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33});
        vecs.push_back('{"divu_m7_2",  1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        33});
        vecs.push_back('{"div_ovf",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        33});
        vecs.push_back('{"div_min_1",  1'b1, 32'h80000000, 32'd1,        32'h80000000, 32'd0,        33});
        vecs.push_back('{"div_7_m2",   1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33});
        vecs.push_back('{"div_m100_m7",1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 33});
        vecs.push_back('{"divu_max",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        33});
        vecs.push_back('{"divu_3_10",  1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        33});

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        foreach (vecs[i])
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                    {vecs[i].r, vecs[i].q}, vecs[i].lat, 0);

        // Hold start for three cycles in DONE.
        run_div("hold3", 1'b0, 32'd1000, 32'd33, {32'd10, 32'd30}, 33, 3);

        // Annul on the 10th BUSY edge, then a normal divide.
        @(negedge clk);
        signed_div = 1'b0; opa = 32'd77; opb = 32'd5; start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        watch_no_ready("annul_no_ready", 40);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, 0);

        // Annul presented while idle must block the start.
        @(negedge clk);
        opa = 32'd9; opb = 32'd2; start = 1'b1; annul = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        watch_no_ready("idle_annul_no_ready", 40);

        // Reset between edges while BUSY.
        @(negedge clk);
        opa = 32'd1000; opb = 32'd3; start = 1'b1;
        repeat (6) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("rst_busy_ready", 64'(ready), 64'd0);
        check("rst_busy_result", result, 64'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        watch_no_ready("rst_busy_idle", 40);

        // Reset between edges while DONE with start held.
        @(negedge clk);
        opa = 32'd50; opb = 32'd4; start = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        check("pre_rst_done_result", result, {32'd2, 32'd12});
        #2;
        resetn = 1'b0;
        #1;
        check("rst_done_ready", 64'(ready), 64'd0);
        check("rst_done_result", result, 64'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        watch_no_ready("rst_done_idle", 40);

        // Randomised operands against a behavioural model.
        for (int i = 0; i < 8; i++) begin
            s = 1'(i % 2);
            x = $urandom;
            y = (i < 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (y == 32'd0) y = 32'd1;
            if (s && x == 32'h80000000 && y == 32'hFFFFFFFF) y = 32'd3;
            if (s) begin
                q = $signed(x) / $signed(y);
                r = $signed(x) % $signed(y);
            end else begin
                q = x / y;
                r = x % y;
            end
            run_div($sformatf("rand%0d", i), s, x, y, {r, q}, 33, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
